// File: rtl/ecc_decoder.sv
// ecc_decoder
// Streaming parity checker for 72-bit ECC-encoded memory words.
// Word layout: [63:0] data, [64] even parity over data, [71:65] reserved (zero).
// A two-stage valid/ready pipeline checks each word, strips the check byte and
// flags bad words in-band. Error statistics are kept for the CSR block.
//
// Ports:
//   sys_clk, sys_rst       clock (rising edge), async active-high reset
//   in_valid/in_ready      input handshake, in_data = {check[7:0], data[63:0]}
//   out_valid/out_ready    output handshake, out_data = data[63:0]
//   out_err                word failed check (out_par_err | out_fmt_err)
//   out_par_err            parity mismatch
//   out_fmt_err            nonzero reserved bits [71:65]
//   err_clr                synchronous clear of the statistics
//   word_count             words delivered (wraps)
//   err_count              erroneous words delivered (saturates)
//   first_err_valid/idx    word_count value at the first error since reset/clear
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds valid and its payload stable until that edge; ready
// may be asserted without valid. in_ready is combinational from out_ready.
module ecc_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_err,
    output logic             out_par_err,
    output logic             out_fmt_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    // Stage A: raw data plus byte-wise partial parities
    logic        a_valid;
    logic [63:0] a_data;
    logic [7:0]  a_part;
    logic        a_p64;
    logic        a_fmt;

    // Stage B: final check result, drives the outputs directly
    logic        b_valid;
    logic [63:0] b_data;
    logic        b_par;
    logic        b_fmt;

    logic        a_adv;
    logic        b_adv;
    logic        out_hs;
    logic [7:0]  in_part;

    // A stage may advance when empty or when the stage after it advances,
    // so bubbles collapse and throughput is one word per cycle.
    assign b_adv    = !b_valid || out_ready;
    assign a_adv    = !a_valid || b_adv;
    assign in_ready = a_adv;
    assign out_hs   = b_valid && out_ready;

    always_comb begin
        in_part = '0;
        for (int i = 0; i < 8; i++) begin
            in_part[i] = ^in_data[8*i +: 8];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            a_valid <= 1'b0;
            a_data  <= '0;
            a_part  <= '0;
            a_p64   <= 1'b0;
            a_fmt   <= 1'b0;
        end else if (a_adv) begin
            a_valid <= in_valid;
            a_data  <= in_data[63:0];
            a_part  <= in_part;
            a_p64   <= in_data[64];
            a_fmt   <= |in_data[71:65];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
            b_par   <= 1'b0;
            b_fmt   <= 1'b0;
        end else if (b_adv) begin
            b_valid <= a_valid;
            b_data  <= a_data;
            b_par   <= (^a_part) ^ a_p64;
            b_fmt   <= a_fmt;
        end
    end

    assign out_valid   = b_valid;
    assign out_data    = b_data;
    assign out_par_err = b_par;
    assign out_fmt_err = b_fmt;
    assign out_err     = b_par | b_fmt;

    // Statistics: a clear in the same cycle as a handshake is applied first,
    // then the delivered word is counted on top of the cleared values.
    logic [CNT_W-1:0] wc_base;
    logic [CNT_W-1:0] ec_base;
    logic [CNT_W-1:0] fei_base;
    logic             fev_base;

    always_comb begin
        wc_base  = word_count;
        ec_base  = err_count;
        fei_base = first_err_idx;
        fev_base = first_err_valid;
        if (err_clr) begin
            wc_base  = '0;
            ec_base  = '0;
            fei_base = '0;
            fev_base = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            word_count      <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            word_count      <= wc_base;
            err_count       <= ec_base;
            first_err_idx   <= fei_base;
            first_err_valid <= fev_base;
            if (out_hs) begin
                word_count <= wc_base + CNT_W'(1);
                if (out_err) begin
                    if (ec_base != '1) begin
                        err_count <= ec_base + CNT_W'(1);
                    end
                    if (!fev_base) begin
                        first_err_idx   <= wc_base;
                        first_err_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_decoder.sv
module tb_ecc_decoder;

    logic        sys_clk;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_err;
    logic        out_par_err;
    logic        out_fmt_err;
    logic        err_clr;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [15:0] first_err_idx;

    // Narrow-counter instance sharing the same stimulus
    logic        s_in_ready;
    logic        s_out_valid;
    logic [63:0] s_out_data;
    logic        s_out_err;
    logic        s_out_par_err;
    logic        s_out_fmt_err;
    logic [3:0]  s_word_count;
    logic [3:0]  s_err_count;
    logic        s_first_err_valid;
    logic [3:0]  s_first_err_idx;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {par_err, fmt_err, data}
    logic [65:0] exp_q[$];

    // Statistics model (16-bit instance)
    logic [15:0] m_wc;
    logic [15:0] m_ec;
    logic [15:0] m_fei;
    logic        m_fev;
    logic        hold_v;

    ecc_decoder dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_par_err(out_par_err), .out_fmt_err(out_fmt_err),
        .err_clr(err_clr), .word_count(word_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    ecc_decoder #(.CNT_W(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_err(s_out_err), .out_par_err(s_out_par_err), .out_fmt_err(s_out_fmt_err),
        .err_clr(err_clr), .word_count(s_word_count), .err_count(s_err_count),
        .first_err_valid(s_first_err_valid), .first_err_idx(s_first_err_idx)
    );

    // Clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the
    // accepting edge with in_valid dropped.
    task automatic push_word(input logic [63:0] data, input logic [7:0] chk);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = {chk, data};
        forever begin
            @(negedge sys_clk);
            if (in_ready || n >= 100) break;
            n++;
        end
        check("push_timeout", 72'(n < 100), 72'(1));
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge sys_clk) begin
        logic [65:0] e;
        logic        hs_err;
        logic        hs;
        if (sys_rst) begin
            hold_v = 1'b0;
        end else begin
            check("word_count", 72'(word_count), 72'(m_wc));
            check("err_count", 72'(err_count), 72'(m_ec));
            check("first_err_valid", 72'(first_err_valid), 72'(m_fev));
            check("first_err_idx", 72'(first_err_idx), 72'(m_fei));
            check("in_ready", 72'(in_ready), 72'(!(exp_q.size() == 2 && !out_ready)));
            if (hold_v) check("out_valid_hold", 72'(out_valid), 72'(1));
            hs     = 1'b0;
            hs_err = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 72'(out_valid), 72'(0));
                end else begin
                    e = exp_q[0];
                    check("out_word", {6'b0, out_par_err, out_fmt_err, out_data}, {6'b0, e});
                    check("out_err", 72'(out_err), 72'(e[65] | e[64]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs     = 1'b1;
                        hs_err = e[65] | e[64];
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_data[64] ^ (^in_data[63:0]), |in_data[71:65], in_data[63:0]});
            end
            hold_v = out_valid && !out_ready;
            if (err_clr) begin
                m_wc = '0; m_ec = '0; m_fei = '0; m_fev = 1'b0;
            end
            if (hs) begin
                if (hs_err) begin
                    if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                    if (!m_fev) begin
                        m_fei = m_wc;
                        m_fev = 1'b1;
                    end
                end
                m_wc = m_wc + 16'd1;
            end
        end
    end

    initial begin
        logic [71:0] w;
        int i;
        int cyc;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        m_wc = '0; m_ec = '0; m_fei = '0; m_fev = 1'b0;
        hold_v = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_data", 72'(out_data), 72'(0));
        check("rst_out_flags", 72'({out_err, out_par_err, out_fmt_err}), 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_counts", {24'b0, word_count, err_count, first_err_idx}, 72'(0));
        check("rst_fev", 72'(first_err_valid), 72'(0));
        idle(3);
        sys_rst = 1'b0;
        idle(1);

        // Good word, two-cycle latency
        push_word(64'h0123_4567_89AB_CDEF, 8'h00);
        @(negedge sys_clk);
        check("lat_stage_a", 72'(out_valid), 72'(0));
        @(negedge sys_clk);
        check("lat_stage_b", 72'(out_valid), 72'(1));
        check("good_data", 72'(out_data), 72'(64'h0123_4567_89AB_CDEF));
        check("good_err", 72'(out_err), 72'(0));
        @(posedge sys_clk);
        #1;
        check("good_wc", 72'(word_count), 72'(1));

        // Clear statistics, then a parity error
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("clr_wc", 72'(word_count), 72'(0));
        push_word(64'h1, 8'h00);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("par_flags", 72'({out_par_err, out_fmt_err, out_err}), 72'(3'b101));
        idle(2);
        check("par_ec", 72'(err_count), 72'(1));
        check("par_fev", 72'(first_err_valid), 72'(1));
        check("par_fei", 72'(first_err_idx), 72'(0));

        // Reserved-bit error
        push_word(64'h0, 8'h02);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("fmt_flags", 72'({out_par_err, out_fmt_err, out_err}), 72'(3'b011));
        idle(2);
        check("fmt_ec", 72'(err_count), 72'(2));
        check("fmt_fei", 72'(first_err_idx), 72'(0));

        // Ten back-to-back words with random backpressure
        i   = 0;
        cyc = 0;
        w   = {8'($urandom_range(0, 1)), $urandom, $urandom};
        while ((i < 10 || exp_q.size() > 0) && cyc < 300) begin
            @(posedge sys_clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (i < 10);
            in_data   = w;
            @(negedge sys_clk);
            if (in_valid && in_ready) begin
                i++;
                w = {8'($urandom_range(0, 1)), $urandom, $urandom};
                if ($urandom_range(0, 3) == 0) w[65] = 1'b1;
            end
            #1;
            cyc++;
        end
        check("stream_timeout", 72'(cyc < 300), 72'(1));
        check("stream_sent", 72'(i), 72'(10));
        @(posedge sys_clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("stream_drained", 72'(exp_q.size()), 72'(0));

        // Twenty erroneous words: saturation on the 4-bit instance
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        for (int k = 0; k < 20; k++) push_word(64'h1, 8'h00);
        idle(4);
        check("sat_wc16", 72'(word_count), 72'(20));
        check("sat_ec16", 72'(err_count), 72'(20));
        check("sat_ec4", 72'(s_err_count), 72'(15));
        check("sat_wc4", 72'(s_word_count), 72'(4));
        check("sat_fei4", 72'(s_first_err_idx), 72'(0));
        check("sat_fev4", 72'(s_first_err_valid), 72'(1));

        // Clear coincident with an erroneous handshake
        out_ready = 1'b0;
        push_word(64'h0, 8'h01);
        idle(2);
        check("clrhs_held", 72'(out_valid), 72'(1));
        err_clr   = 1'b1;
        out_ready = 1'b1;
        idle(1);
        err_clr   = 1'b0;
        check("clrhs_wc", 72'(word_count), 72'(1));
        check("clrhs_ec", 72'(err_count), 72'(1));
        check("clrhs_fei", 72'(first_err_idx), 72'(0));
        check("clrhs_fev", 72'(first_err_valid), 72'(1));

        // Reset with two words in flight
        out_ready = 1'b0;
        push_word(64'hAAAA_5555_0000_FFFF, 8'h00);
        push_word(64'h1234, 8'h00);
        check("full_in_ready", 72'(in_ready), 72'(0));
        sys_rst = 1'b1;
        exp_q.delete();
        m_wc = '0; m_ec = '0; m_fei = '0; m_fev = 1'b0;
        #1;
        check("mrst_out_valid", 72'(out_valid), 72'(0));
        check("mrst_out_data", 72'(out_data), 72'(0));
        check("mrst_counts", {24'b0, word_count, err_count, first_err_idx}, 72'(0));
        check("mrst_fev", 72'(first_err_valid), 72'(0));
        check("mrst_counts4", 72'({s_word_count, s_err_count, s_first_err_valid}), 72'(0));
        check("mrst_in_ready", 72'(in_ready), 72'(1));
        idle(2);
        sys_rst   = 1'b0;
        out_ready = 1'b1;
        idle(1);
        push_word(64'hFEED, 8'h00);
        idle(4);
        check("post_rst_wc", 72'(word_count), 72'(1));
        check("post_rst_drained", 72'(exp_q.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
